// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID decode, load-use stall, branch flush and ID/EX -> MEM/WB control pipeline.
// Ports: clk_i/rst_i (async active-high); id_* = ID-stage instruction fields;
// stall_o/flush_o/id_branch_o = combinational hazard outputs; ex_*/mem_*/wb_* = staged
// control bits and rd; bubble_cnt_o/flush_cnt_o = saturating event counters.
module ctrl_pipe #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [6:0]        id_op_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rs_equal_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              id_branch_o,
    output logic [1:0]        ex_alu_op_o,
    output logic              ex_alu_src_o,
    output logic              ex_mem_read_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              mem_mem_read_o,
    output logic              mem_mem_write_o,
    output logic              mem_reg_write_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic              wb_reg_write_o,
    output logic              wb_mem2reg_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic is_r, is_i, is_lw, is_sw, is_beq, rs1_used, rs2_used;
    // {reg_write, mem2reg, mem_read, mem_write, alu_op[1:0], alu_src, branch}
    logic [7:0] ctl;
    // EX keeps {reg_write, mem2reg, mem_read, mem_write, alu_op, alu_src}
    logic [6:0] ex_ctl_q, ex_ctl_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, wb_rd_q;
    // MEM keeps {reg_write, mem2reg, mem_read, mem_write}; WB keeps {reg_write, mem2reg}
    logic [3:0] mem_ctl_q;
    logic [1:0] wb_ctl_q;
    logic [CNT_W-1:0] bub_q, bub_d, fl_q, fl_d;

    always_comb begin
        is_r     = id_valid_i && id_op_i == OP_R;
        is_i     = id_valid_i && id_op_i == OP_I;
        is_lw    = id_valid_i && id_op_i == OP_LW;
        is_sw    = id_valid_i && id_op_i == OP_SW;
        is_beq   = id_valid_i && id_op_i == OP_BEQ;
        ctl      = is_r ? 8'b1000_1000 : is_i ? 8'b1000_1110 : is_lw ? 8'b1110_0010 :
                   is_sw ? 8'b0001_0010 : is_beq ? 8'b0000_0111 : 8'b0;
        rs1_used = is_r || is_i || is_lw || is_sw || is_beq;
        rs2_used = is_r || is_sw || is_beq;
        stall_o  = ex_ctl_q[4] && ex_rd_q != '0 &&
                   ((rs1_used && id_rs1_i == ex_rd_q) || (rs2_used && id_rs2_i == ex_rd_q));
        flush_o  = ctl[0] && id_rs_equal_i && !stall_o;
        ex_ctl_d = stall_o ? '0 : ctl[7:1];
        ex_rd_d  = stall_o ? '0 : id_rd_i;
        bub_d    = (stall_o && !(&bub_q)) ? bub_q + CNT_W'(1) : bub_q;
        fl_d     = (flush_o && !(&fl_q)) ? fl_q + CNT_W'(1) : fl_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_ctl_q  <= '0;
            ex_rd_q   <= '0;
            mem_ctl_q <= '0;
            mem_rd_q  <= '0;
            wb_ctl_q  <= '0;
            wb_rd_q   <= '0;
            bub_q     <= '0;
            fl_q      <= '0;
        end else begin
            ex_ctl_q  <= ex_ctl_d;
            ex_rd_q   <= ex_rd_d;
            mem_ctl_q <= ex_ctl_q[6:3];
            mem_rd_q  <= ex_rd_q;
            wb_ctl_q  <= mem_ctl_q[3:2];
            wb_rd_q   <= mem_rd_q;
            bub_q     <= bub_d;
            fl_q      <= fl_d;
        end
    end

    assign id_branch_o     = ctl[0];
    assign ex_alu_op_o     = ex_ctl_q[2:1];
    assign ex_alu_src_o    = ex_ctl_q[0];
    assign ex_mem_read_o   = ex_ctl_q[4];
    assign ex_rd_o         = ex_rd_q;
    assign mem_reg_write_o = mem_ctl_q[3];
    assign mem_mem_read_o  = mem_ctl_q[1];
    assign mem_mem_write_o = mem_ctl_q[0];
    assign mem_rd_o        = mem_rd_q;
    assign wb_reg_write_o  = wb_ctl_q[1];
    assign wb_mem2reg_o    = wb_ctl_q[0];
    assign wb_rd_o         = wb_rd_q;
    assign bubble_cnt_o    = bub_q;
    assign flush_cnt_o     = fl_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scoreboard bench for ctrl_pipe.
module tb_ctrl_pipe;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011,
                           SW = 7'b0100011, BEQ = 7'b1100011, NOP = 7'b0000000;
    localparam int F_STALL = 0, F_FLUSH = 1, F_BR = 2, F_EXALU = 3, F_EXSRC = 4, F_EXMR = 5,
                   F_EXRD = 6, F_MEMMR = 7, F_MEMMW = 8, F_MEMRW = 9, F_MEMRD = 10,
                   F_WBRW = 11, F_WBM2R = 12, F_WBRD = 13, F_BCNT = 14, F_FCNT = 15,
                   F_BCNT2 = 16, F_ALLREG = 17;

    logic clk, rst, valid, eq;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic stall, flush, br, ex_src, ex_mr, mem_mr, mem_mw, mem_rw, wb_rw, wb_m2r;
    logic [1:0] ex_alu;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic [15:0] bcnt, fcnt;
    logic stall2, flush2, br2, ex_src2, ex_mr2, mem_mr2, mem_mw2, mem_rw2, wb_rw2, wb_m2r2;
    logic [1:0] ex_alu2, bcnt2, fcnt2;
    logic [4:0] ex_rd2, mem_rd2, wb_rd2;

    ctrl_pipe dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_op_i(op), .id_rs1_i(rs1),
        .id_rs2_i(rs2), .id_rd_i(rd), .id_rs_equal_i(eq), .stall_o(stall), .flush_o(flush),
        .id_branch_o(br), .ex_alu_op_o(ex_alu), .ex_alu_src_o(ex_src), .ex_mem_read_o(ex_mr),
        .ex_rd_o(ex_rd), .mem_mem_read_o(mem_mr), .mem_mem_write_o(mem_mw),
        .mem_reg_write_o(mem_rw), .mem_rd_o(mem_rd), .wb_reg_write_o(wb_rw),
        .wb_mem2reg_o(wb_m2r), .wb_rd_o(wb_rd), .bubble_cnt_o(bcnt), .flush_cnt_o(fcnt)
    );

    ctrl_pipe #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_op_i(op), .id_rs1_i(rs1),
        .id_rs2_i(rs2), .id_rd_i(rd), .id_rs_equal_i(eq), .stall_o(stall2), .flush_o(flush2),
        .id_branch_o(br2), .ex_alu_op_o(ex_alu2), .ex_alu_src_o(ex_src2), .ex_mem_read_o(ex_mr2),
        .ex_rd_o(ex_rd2), .mem_mem_read_o(mem_mr2), .mem_mem_write_o(mem_mw2),
        .mem_reg_write_o(mem_rw2), .mem_rd_o(mem_rd2), .wb_reg_write_o(wb_rw2),
        .wb_mem2reg_o(wb_m2r2), .wb_rd_o(wb_rd2), .bubble_cnt_o(bcnt2), .flush_cnt_o(fcnt2)
    );

    typedef struct {
        string       n;
        int          f;
        logic [63:0] v;
    } chk_t;
    chk_t q[$];
    int checks = 0, errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] get(input int f);
        case (f)
            F_STALL:  get = 64'(stall);
            F_FLUSH:  get = 64'(flush);
            F_BR:     get = 64'(br);
            F_EXALU:  get = 64'(ex_alu);
            F_EXSRC:  get = 64'(ex_src);
            F_EXMR:   get = 64'(ex_mr);
            F_EXRD:   get = 64'(ex_rd);
            F_MEMMR:  get = 64'(mem_mr);
            F_MEMMW:  get = 64'(mem_mw);
            F_MEMRW:  get = 64'(mem_rw);
            F_MEMRD:  get = 64'(mem_rd);
            F_WBRW:   get = 64'(wb_rw);
            F_WBM2R:  get = 64'(wb_m2r);
            F_WBRD:   get = 64'(wb_rd);
            F_BCNT:   get = 64'(bcnt);
            F_FCNT:   get = 64'(fcnt);
            F_BCNT2:  get = 64'(bcnt2);
            default:  get = 64'({ex_alu, ex_src, ex_mr, ex_rd, mem_mr, mem_mw, mem_rw, mem_rd,
                                 wb_rw, wb_m2r, wb_rd, bcnt, fcnt, bcnt2, fcnt2});
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [63:0] act;
            c = q.pop_front();
            act = get(c.f);
            checks++;
            if (act !== c.v) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h at %0t", c.n, act, c.v, $time);
            end
        end
    end

    task automatic ck(input string n, input int f, input logic [63:0] v);
        chk_t c;
        c.n = n;
        c.f = f;
        c.v = v;
        q.push_back(c);
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic e);
        @(posedge clk);
        #1;
        valid = v; op = o; rs1 = a; rs2 = b; rd = d; eq = e;
    endtask

    int sat[5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1; valid = 1'b0; op = NOP; rs1 = '0; rs2 = '0; rd = '0; eq = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        drive(0, NOP, 0, 0, 0, 0);
        ck("rst_regs", F_ALLREG, 0); ck("rst_stall", F_STALL, 0);
        ck("rst_flush", F_FLUSH, 0); ck("rst_br", F_BR, 0);
        drive(1, R, 1, 2, 3, 0);
        ck("add_br", F_BR, 0); ck("add_stall", F_STALL, 0);
        drive(0, NOP, 0, 0, 0, 0);
        ck("add_ex_alu", F_EXALU, 2); ck("add_ex_rd", F_EXRD, 3);
        ck("add_ex_src", F_EXSRC, 0); ck("add_ex_mr", F_EXMR, 0);
        drive(0, NOP, 0, 0, 0, 0);
        ck("add_mem_rw", F_MEMRW, 1); ck("add_mem_rd", F_MEMRD, 3);
        ck("add_mem_mr", F_MEMMR, 0); ck("add_mem_mw", F_MEMMW, 0);
        drive(0, NOP, 0, 0, 0, 0);
        ck("add_wb_rw", F_WBRW, 1); ck("add_wb_rd", F_WBRD, 3); ck("add_wb_m2r", F_WBM2R, 0);
        drive(0, NOP, 0, 0, 0, 0);
        ck("add_drained", F_ALLREG, 0);
        drive(1, LW, 7, 0, 1, 0);
        ck("lw_nostall", F_STALL, 0);
        drive(1, R, 1, 5, 2, 0);
        ck("lu_stall", F_STALL, 1); ck("lu_ex_mr", F_EXMR, 1); ck("lu_ex_rd", F_EXRD, 1);
        ck("lu_flush", F_FLUSH, 0); ck("lu_bcnt0", F_BCNT, 0);
        drive(1, R, 1, 5, 2, 0);
        ck("lu_stall_drop", F_STALL, 0); ck("bub_ex_mr", F_EXMR, 0); ck("bub_ex_alu", F_EXALU, 0);
        ck("bub_ex_rd", F_EXRD, 0); ck("lw_mem_mr", F_MEMMR, 1); ck("lw_mem_rd", F_MEMRD, 1);
        ck("lu_bcnt1", F_BCNT, 1);
        drive(0, NOP, 0, 0, 0, 0);
        ck("add_late_alu", F_EXALU, 2); ck("add_late_rd", F_EXRD, 2);
        ck("lw_wb_m2r", F_WBM2R, 1); ck("lw_wb_rw", F_WBRW, 1); ck("lw_wb_rd", F_WBRD, 1);
        ck("bub_mem_rw", F_MEMRW, 0); ck("bcnt_hold", F_BCNT, 1);
        drive(1, LW, 3, 0, 0, 0);
        ck("lw0_nostall", F_STALL, 0);
        drive(1, R, 0, 0, 4, 0);
        ck("x0_nostall", F_STALL, 0); ck("lw0_ex_mr", F_EXMR, 1); ck("lw0_ex_rd", F_EXRD, 0);
        drive(1, LW, 3, 0, 1, 0);
        ck("lw1_nostall", F_STALL, 0);
        drive(1, I, 3, 1, 2, 0);
        ck("addi_rs2_nostall", F_STALL, 0); ck("lw1_ex_mr", F_EXMR, 1); ck("lw1_ex_rd", F_EXRD, 1);
        drive(0, NOP, 0, 0, 0, 0);
        ck("addi_ex_alu", F_EXALU, 3); ck("addi_ex_src", F_EXSRC, 1);
        ck("addi_ex_rd", F_EXRD, 2); ck("addi_bcnt", F_BCNT, 1);
        drive(1, LW, 3, 0, 6, 0);
        drive(1, SW, 9, 6, 0, 0);
        ck("sw_rs2_stall", F_STALL, 1);
        drive(1, SW, 9, 6, 0, 0);
        ck("sw_stall_drop", F_STALL, 0); ck("sw_bub_mr", F_EXMR, 0); ck("sw_bcnt", F_BCNT, 2);
        drive(0, NOP, 0, 0, 0, 0);
        ck("sw_ex_alu", F_EXALU, 0); ck("sw_ex_src", F_EXSRC, 1); ck("sw_ex_mr", F_EXMR, 0);
        drive(0, NOP, 0, 0, 0, 0);
        ck("sw_mem_mw", F_MEMMW, 1); ck("sw_mem_rw", F_MEMRW, 0);
        drive(1, BEQ, 1, 2, 0, 1);
        ck("beq_br", F_BR, 1); ck("beq_flush", F_FLUSH, 1);
        ck("beq_stall", F_STALL, 0); ck("beq_fcnt0", F_FCNT, 0);
        drive(0, NOP, 0, 0, 0, 0);
        ck("beq_fcnt1", F_FCNT, 1); ck("beq_flush_drop", F_FLUSH, 0); ck("nop_br", F_BR, 0);
        ck("beq_ex_alu", F_EXALU, 1); ck("beq_ex_src", F_EXSRC, 1);
        drive(1, BEQ, 1, 2, 0, 0);
        ck("beq_ne_br", F_BR, 1); ck("beq_ne_flush", F_FLUSH, 0);
        drive(0, NOP, 0, 0, 0, 0);
        ck("beq_ne_fcnt", F_FCNT, 1);
        drive(0, BEQ, 1, 2, 3, 1);
        ck("inval_br", F_BR, 0); ck("inval_flush", F_FLUSH, 0);
        drive(1, 7'h6f, 1, 2, 3, 1);
        ck("inval_ex_alu", F_EXALU, 0); ck("inval_ex_src", F_EXSRC, 0);
        ck("inval_ex_mr", F_EXMR, 0); ck("unk_br", F_BR, 0); ck("unk_flush", F_FLUSH, 0);
        drive(1, LW, 3, 0, 4, 0);
        ck("unk_ex_alu", F_EXALU, 0); ck("unk_ex_src", F_EXSRC, 0); ck("unk_stall", F_STALL, 0);
        drive(1, BEQ, 4, 4, 0, 1);
        ck("lub_stall", F_STALL, 1); ck("lub_flush", F_FLUSH, 0); ck("lub_br", F_BR, 1);
        ck("lub_fcnt", F_FCNT, 1); ck("lub_bcnt", F_BCNT, 2);
        drive(1, BEQ, 4, 4, 0, 1);
        ck("lub_stall2", F_STALL, 0); ck("lub_flush2", F_FLUSH, 1); ck("lub_bcnt2", F_BCNT, 3);
        drive(0, NOP, 0, 0, 0, 0);
        ck("lub_fcnt2", F_FCNT, 2); ck("lub_bcnt3", F_BCNT, 3);
        drive(1, LW, 3, 0, 1, 0);
        drive(0, NOP, 0, 0, 0, 0);
        ck("pre_rst_ex_mr", F_EXMR, 1); ck("pre_rst_ex_rd", F_EXRD, 1);
        drive(0, NOP, 0, 0, 0, 0);
        #1 rst = 1'b1;
        ck("async_rst", F_ALLREG, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        drive(1, R, 1, 2, 3, 0);
        ck("post_rst_stall", F_STALL, 0); ck("post_rst_regs", F_ALLREG, 0);
        drive(0, NOP, 0, 0, 0, 0);
        ck("post_rst_ex_alu", F_EXALU, 2); ck("post_rst_ex_rd", F_EXRD, 3);
        ck("post_rst_mem_mr", F_MEMMR, 0); ck("post_rst_wb_m2r", F_WBM2R, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, LW, 3, 0, 1, 0);
            drive(1, R, 1, 5, 2, 0);
            ck("sat_stall", F_STALL, 1);
            drive(1, R, 1, 5, 2, 0);
            ck("sat_bcnt2", F_BCNT2, 64'(sat[i])); ck("sat_bcnt16", F_BCNT, 64'(i + 1));
        end
        drive(0, NOP, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the five-stage RISC-V core. It decodes the ID-stage opcode into the control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and inserts bubbles, and raises an IF/ID flush on taken branches resolved in ID. It also keeps saturating bubble and flush counters for performance debug.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of each event counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  the ID instruction is real; 0 makes it decode as a NOP.
- id_op_i  in  7  opcode of the ID instruction.
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW each  register fields of the ID instruction.
- id_rs_equal_i  in  1  rs1 == rs2 comparison result from the ID-stage comparator.
- stall_o  out  1  load-use stall: hold PC and IF/ID.
- flush_o  out  1  taken branch: clear IF/ID.
- id_branch_o  out  1  the ID instruction is beq.
- ex_alu_op_o  out  2  ALUOp in EX.
- ex_alu_src_o  out  1  ALUSrc in EX.
- ex_mem_read_o  out  1  MemRead in EX.
- ex_rd_o  out  REG_AW  destination register in EX.
- mem_mem_read_o, mem_mem_write_o, mem_reg_write_o  out  1 each  control bits in MEM.
- mem_rd_o  out  REG_AW  destination register in MEM.
- wb_reg_write_o, wb_mem2reg_o  out  1 each  control bits in WB.
- wb_rd_o  out  REG_AW  destination register in WB.
- bubble_cnt_o, flush_cnt_o  out  CNT_W each  event counters.

## Operation
Decode is combinational and uses id_op_i. The fields are RegWrite, Mem2Reg, MemRead, MemWrite, ALUOp, ALUSrc, Branch:
- 0110011 (R): 1, 0, 0, 0, 10, 0, 0.
- 0010011 (I-ALU): 1, 0, 0, 0, 11, 1, 0.
- 0000011 (lw): 1, 1, 1, 0, 00, 1, 0.
- 0100011 (sw): 0, 0, 0, 1, 00, 1, 0.
- 1100011 (beq): 0, 0, 0, 0, 01, 1, 1.
- Any other opcode, or id_valid_i = 0: all fields 0.
- No field is ever X; unused fields are driven to 0.

Register-use qualification:
- rs1 counts as used for R, I-ALU, lw, sw and beq.
- rs2 counts as used for R, sw and beq only.

Load-use hazard:
- stall_o = ex_mem_read_o && ex_rd_o != 0 && ((rs1 used && id_rs1_i == ex_rd_o) || (rs2 used && id_rs2_i == ex_rd_o)).

Branch:
- flush_o = decoded Branch && id_rs_equal_i && !stall_o.
- Stall has priority over flush. A stalled branch is re-evaluated on the next cycle.

ID/EX register:
- Loads the decoded bundle and id_rd_i each cycle.
- When stall_o = 1 it loads a bubble instead: all control bits 0 and rd = 0.

Downstream registers:
- EX/MEM and MEM/WB advance every cycle unconditionally.
- RegWrite and Mem2Reg ride along to WB; MemRead and MemWrite ride along to MEM; rd rides along to WB.

Counters:
- bubble_cnt_o increments on each edge where stall_o = 1.
- flush_cnt_o increments on each edge where flush_o = 1.
- Both saturate at 2^CNT_W − 1 and never wrap.

## Timing
- Reset: every pipeline register and both counters are 0 immediately on rst_i assertion, independent of clk_i. All registered outputs therefore read 0.
- stall_o, flush_o and id_branch_o are combinational and not reset. With all registers at 0 and id_valid_i = 0, they are 0.
- Latency from ID decode: EX outputs after 1 edge, MEM outputs after 2 edges, WB outputs after 3 edges.
- A load-use pair inserts exactly one bubble. The following cycle has a 0 in ex_mem_read_o, so stall_o drops.
- Reset deasserted mid-stream: the pipeline restarts empty and no stale control survives.
- Counter increment and saturation are evaluated on the same edge.

## Test plan
- Reset: assert rst_i mid-cycle with lw in flight -> all registered outputs and counters read 0 before the next clk_i edge.
- add x3,x1,x2 then NOPs -> ex_alu_op_o = 10 and ex_rd_o = 3 after edge 1; wb_reg_write_o = 1 and wb_rd_o = 3 after edge 3; all outputs 0 after edge 4.
- lw x1 followed by add x2,x1,x5 -> stall_o = 1 for exactly one cycle; the EX stage shows a bubble (all 0); add reaches EX one cycle later; bubble_cnt_o = 1.
  - Variant, lw x0 followed by an x0 use -> no stall.
  - Variant, lw x1 followed by addi x2,x3 whose rs2 field is 1 -> no stall.
- beq with id_rs_equal_i = 1 -> flush_o = 1 for one cycle and flush_cnt_o = 1.
  - Variant, id_rs_equal_i = 0 -> flush_o = 0.
- lw x4 followed by beq x4,x4 with id_rs_equal_i = 1 -> cycle 1: stall_o = 1, flush_o = 0; cycle 2: flush_o = 1.
- CNT_W = 2 with 5 consecutive load-use pairs -> bubble_cnt_o sequence 1, 2, 3, 3, 3.
